// File: rtl/pc_gen_unit_pkg.sv
// Shared types and constants for the JAMIA fetch-stage program-counter generator.
package jamia_pc_pkg;

    typedef enum logic [1:0] {
        RESET_STATE     = 2'b00,
        TRAP_RETURN     = 2'b01,
        TRAP_TAKEN      = 2'b10,
        OPERATING_STATE = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        RESET = 2'b00,
        BOOT  = 2'b01,
        RUN   = 2'b10
    } fsm_state_e;

    localparam int PC_INC = 4;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Instruction-bus handshake between the PC generator (master) and the fetch path (slave).
interface pc_gen_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] i_addr_out;
    logic            i_req_out;
    logic            stall_in;

    modport master (output i_addr_out, output i_req_out, input stall_in);
    modport slave  (input i_addr_out, input i_req_out, output stall_in);
endinterface

// File: rtl/pc_gen_unit_trap_vec.sv
// Trap entry address: mtvec base in direct mode, base + 4*cause for vectored interrupts.
module pc_trap_vec #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic [XLEN-3:0]    mtvec_base_i,
    input  logic               mtvec_mode_i,
    input  logic [CAUSE_W-1:0] trap_cause_i,
    input  logic               trap_is_irq_i,
    output logic [XLEN-1:0]    trap_addr_o
);
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;

    assign base   = {mtvec_base_i, 2'b00};
    // Exceptions always go to the base, even when vectored mode is selected.
    assign offset = (mtvec_mode_i && trap_is_irq_i) ? XLEN'({trap_cause_i, 2'b00}) : '0;
    assign trap_addr_o = base + offset;
endmodule

// File: rtl/pc_gen_unit.sv
// Registered fetch PC with prioritised redirect selection, stall-time redirect buffering
// and misaligned branch-target detection.
module pc_gen_unit
    import jamia_pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              IALIGN       = 32,
    parameter int              VEC_CAUSES   = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [1:0]                    pc_src_in,
    input  logic                          branch_taken_in,
    input  logic [XLEN-2:0]               iaddr_in,
    input  logic [XLEN-1:0]               epc_in,
    input  logic [XLEN-3:0]               mtvec_base_in,
    input  logic                          mtvec_mode_in,
    input  logic [$clog2(VEC_CAUSES)-1:0] trap_cause_in,
    input  logic                          trap_is_irq_in,
    pc_gen_unit_if.master                 ibus,
    output logic [XLEN-1:0]               pc_out,
    output logic [XLEN-1:0]               pc_plus_4_out,
    output logic                          misaligned_instr_out,
    output logic                          redirect_pending_out
);
    localparam int CAUSE_W = $clog2(VEC_CAUSES);

    pc_src_e    pc_src;
    fsm_state_e state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pc_inc, branch_addr, trap_addr, target;
    logic            redirect, misaligned;

    assign pc_src      = pc_src_e'(pc_src_in);
    assign pc_inc      = pc_q + XLEN'(PC_INC);
    assign branch_addr = {iaddr_in, 1'b0};

    pc_trap_vec #(
        .XLEN    (XLEN),
        .CAUSE_W (CAUSE_W)
    ) u_trap_vec (
        .mtvec_base_i  (mtvec_base_in),
        .mtvec_mode_i  (mtvec_mode_in),
        .trap_cause_i  (trap_cause_in),
        .trap_is_irq_i (trap_is_irq_in),
        .trap_addr_o   (trap_addr)
    );

    // A buffered redirect only competes with the sequential increment; any new redirect beats it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        target   = pc_inc;
        redirect = 1'b1;
        unique case (pc_src)
            RESET_STATE: target = RESET_VECTOR;
            TRAP_TAKEN:  target = trap_addr;
            TRAP_RETURN: target = epc_in;
            OPERATING_STATE: begin
                if (branch_taken_in) begin
                    target = branch_addr;
                end else begin
                    redirect = 1'b0;
                    target   = pend_valid_q ? pend_addr_q : pc_inc;
                end
            end
        endcase
    end

    assign misaligned = (IALIGN == 32) && (state_q == RUN) && (pc_src == OPERATING_STATE)
                        && branch_taken_in && iaddr_in[0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_addr_d  = pend_addr_q;
        pend_valid_d = pend_valid_q;
        case (state_q)
            RESET: state_d = BOOT;
            BOOT: begin
                state_d      = RUN;
                pc_d         = RESET_VECTOR;
                pend_valid_d = 1'b0;
            end
            RUN: begin
                // A misaligned branch is dropped entirely; the trap controller redirects next.
                if (!misaligned) begin
                    if (!ibus.stall_in) begin
                        pc_d         = target;
                        pend_valid_d = 1'b0;
                    end else if (redirect) begin
                        pend_addr_d  = target;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = RESET;
        endcase
        if (pc_src == RESET_STATE) begin
            state_d = BOOT;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= RESET;
            pc_q         <= RESET_VECTOR;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign pc_out               = pc_q;
    assign pc_plus_4_out        = pc_inc;
    assign ibus.i_addr_out      = (state_q == RUN) ? pc_q : '0;
    assign ibus.i_req_out       = (state_q == RUN);
    assign misaligned_instr_out = misaligned;
    assign redirect_pending_out = pend_valid_q;
endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed vector table, reset-mid-stall sequence, random run vs model.
module tb_pc_gen_unit;
    localparam logic [31:0] RV = 32'h0000_0100;

    typedef struct {
        logic        stall;
        logic [1:0]  src;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] epc;
        logic [31:0] tvec;
        logic        mode;
        logic        irq;
        logic [3:0]  cause;
        logic        exp_mis;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic        exp_pend;
    } vec_t;

    logic        clk, rst_n;
    logic [1:0]  pc_src;
    logic        br_taken;
    logic [30:0] iaddr;
    logic [31:0] epc;
    logic [29:0] tbase;
    logic        tmode;
    logic [3:0]  tcause;
    logic        tirq;
    logic [31:0] pc, pc4;
    logic        mis, pend;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: phase 0 = reset, 1 = boot, 2 = run.
    int          m_phase;
    logic [31:0] m_pc, m_pa;
    logic        m_pv;

    pc_gen_unit_if #(.XLEN(32)) ibus ();

    pc_gen_unit #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .IALIGN       (32),
        .VEC_CAUSES   (16)
    ) dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .pc_src_in            (pc_src),
        .branch_taken_in      (br_taken),
        .iaddr_in             (iaddr),
        .epc_in               (epc),
        .mtvec_base_in        (tbase),
        .mtvec_mode_in        (tmode),
        .trap_cause_in        (tcause),
        .trap_is_irq_in       (tirq),
        .ibus                 (ibus),
        .pc_out               (pc),
        .pc_plus_4_out        (pc4),
        .misaligned_instr_out (mis),
        .redirect_pending_out (pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic [1:0] src, input logic br,
                         input logic [31:0] tgt, input logic [31:0] e, input logic [31:0] tv,
                         input logic mode, input logic irq, input logic [3:0] cause);
        ibus.stall_in = stall;
        pc_src        = src;
        br_taken      = br;
        iaddr         = tgt[31:1];
        epc           = e;
        tbase         = tv[31:2];
        tmode         = mode;
        tirq          = irq;
        tcause        = cause;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e_pc, input logic e_req,
                              input logic e_pend);
        check({tag, "_pc"}, pc, e_pc);
        check({tag, "_pc4"}, pc4, e_pc + 32'd4);
        check({tag, "_iaddr"}, ibus.i_addr_out, e_req ? e_pc : 32'h0);
        check({tag, "_ireq"}, {31'b0, ibus.i_req_out}, {31'b0, e_req});
        check({tag, "_pend"}, {31'b0, pend}, {31'b0, e_pend});
    endtask

    function automatic vec_t mk(input logic stall, input logic [1:0] src, input logic br,
                                input logic [31:0] tgt, input logic [31:0] e,
                                input logic [31:0] tv, input logic mode, input logic irq,
                                input logic [3:0] cause, input logic x_mis,
                                input logic [31:0] x_pc, input logic x_req, input logic x_pend);
        vec_t v;
        v.stall = stall; v.src = src; v.br = br; v.tgt = tgt; v.epc = e; v.tvec = tv;
        v.mode = mode; v.irq = irq; v.cause = cause;
        v.exp_mis = x_mis; v.exp_pc = x_pc; v.exp_req = x_req; v.exp_pend = x_pend;
        return v;
    endfunction

    // Spec-level reference: choose the next fetch address by priority, then apply stall rules.
    function automatic logic [31:0] ref_target(input logic [1:0] src, input logic br,
                                               input logic [31:0] tgt, input logic [31:0] e,
                                               input logic [31:0] tv, input logic mode,
                                               input logic irq, input logic [3:0] cause);
        logic [31:0] base;
        base = tv & 32'hFFFF_FFFC;
        case (src)
            2'b00:   return RV;
            2'b10:   return (mode && irq) ? base + 32'(cause) * 32'd4 : base;
            2'b01:   return e;
            default: begin
                if (br)   return tgt & 32'hFFFF_FFFE;
                if (m_pv) return m_pa;
                return m_pc + 32'd4;
            end
        endcase
    endfunction

    vec_t tbl[23];

    initial begin
        logic        r_stall, r_br, r_mode, r_irq, e_mis, redir;
        logic [1:0]  r_src;
        logic [31:0] r_tgt, r_epc, r_tvec, nxt;
        logic [3:0]  r_cause;
        int          sel;

        tbl[0]  = mk(0, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h100,      0, 0);
        tbl[1]  = mk(0, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h100,      1, 0);
        tbl[2]  = mk(0, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h104,      1, 0);
        tbl[3]  = mk(0, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h108,      1, 0);
        tbl[4]  = mk(0, 2'b11, 1, 32'h200,       32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h200,      1, 0);
        tbl[5]  = mk(0, 2'b11, 1, 32'h400,       32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h400,      1, 0);
        tbl[6]  = mk(1, 2'b11, 1, 32'h800,       32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h400,      1, 1);
        tbl[7]  = mk(1, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h400,      1, 1);
        tbl[8]  = mk(1, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h400,      1, 1);
        tbl[9]  = mk(0, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h800,      1, 0);
        tbl[10] = mk(0, 2'b10, 0, 32'h0,         32'h0,   32'h1000, 1, 1, 4'd3, 0, 32'h100C,     1, 0);
        tbl[11] = mk(0, 2'b10, 0, 32'h0,         32'h0,   32'h1000, 1, 0, 4'd3, 0, 32'h1000,     1, 0);
        tbl[12] = mk(0, 2'b11, 1, 32'h402,       32'h0,   32'h0,    0, 0, 4'd0, 1, 32'h1000,     1, 0);
        tbl[13] = mk(0, 2'b10, 1, 32'h600,       32'h0,   32'h2000, 0, 1, 4'd5, 0, 32'h2000,     1, 0);
        tbl[14] = mk(0, 2'b01, 0, 32'h0,         32'h3000, 32'h0,   0, 0, 4'd0, 0, 32'h3000,     1, 0);
        tbl[15] = mk(0, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h3004,     1, 0);
        tbl[16] = mk(0, 2'b11, 1, 32'hFFFF_FFFC, 32'h0,   32'h0,    0, 0, 4'd0, 0, 32'hFFFF_FFFC, 1, 0);
        tbl[17] = mk(0, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h0,        1, 0);
        tbl[18] = mk(1, 2'b11, 1, 32'h500,       32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h0,        1, 1);
        tbl[19] = mk(0, 2'b11, 1, 32'h700,       32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h700,      1, 0);
        tbl[20] = mk(1, 2'b11, 1, 32'h900,       32'h0,   32'h0,    0, 0, 4'd0, 0, 32'h700,      1, 1);
        tbl[21] = mk(1, 2'b01, 0, 32'h0,         32'hA00, 32'h0,    0, 0, 4'd0, 0, 32'h700,      1, 1);
        tbl[22] = mk(0, 2'b11, 0, 32'h0,         32'h0,   32'h0,    0, 0, 4'd0, 0, 32'hA00,      1, 0);

        rst_n = 1'b0;
        drive(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 0, 0, 4'd0);
        repeat (2) @(negedge clk);
        check_regs("reset", RV, 1'b0, 1'b0);
        check("reset_mis", {31'b0, mis}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].stall, tbl[i].src, tbl[i].br, tbl[i].tgt, tbl[i].epc, tbl[i].tvec,
                  tbl[i].mode, tbl[i].irq, tbl[i].cause);
            #1;
            check($sformatf("vec%0d_mis", i), {31'b0, mis}, {31'b0, tbl[i].exp_mis});
            @(posedge clk);
            #1;
            check_regs($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_req, tbl[i].exp_pend);
            @(negedge clk);
        end

        // Reset asserted while a stalled redirect is buffered.
        drive(1, 2'b11, 1, 32'hB00, 32'h0, 32'h0, 0, 0, 4'd0);
        @(posedge clk);
        #1;
        check("midstall_pend_set", {31'b0, pend}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_regs("midstall_rst", RV, 1'b0, 1'b0);
        drive(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 0, 0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_regs("rel_boot", RV, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_regs("rel_run", RV, 1'b1, 1'b0);
        @(negedge clk);

        m_phase = 2;
        m_pc    = RV;
        m_pv    = 1'b0;
        m_pa    = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            r_stall = ($urandom_range(0, 3) == 0);
            sel     = $urandom_range(0, 99);
            if (sel < 3 && !r_stall) r_src = 2'b00;
            else if (sel < 10)       r_src = 2'b10;
            else if (sel < 16)       r_src = 2'b01;
            else                     r_src = 2'b11;
            r_br    = ($urandom_range(0, 2) == 0);
            r_tgt   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            if (!m_pv && $urandom_range(0, 7) == 0) r_tgt[1] = 1'b1;
            r_epc   = $urandom & 32'hFFFF_FFFC;
            r_tvec  = $urandom;
            r_mode  = $urandom_range(0, 1) == 1;
            r_irq   = $urandom_range(0, 1) == 1;
            r_cause = 4'($urandom_range(0, 15));

            drive(r_stall, r_src, r_br, r_tgt, r_epc, r_tvec, r_mode, r_irq, r_cause);
            e_mis = (m_phase == 2) && (r_src == 2'b11) && r_br && r_tgt[1];
            nxt   = ref_target(r_src, r_br, r_tgt, r_epc, r_tvec, r_mode, r_irq, r_cause);
            redir = (r_src != 2'b11) || r_br;
            #1;
            check("rnd_mis", {31'b0, mis}, {31'b0, e_mis});

            if (m_phase == 1) begin
                m_pc = RV;
                m_pv = 1'b0;
            end else if (m_phase == 2 && !e_mis) begin
                if (!r_stall) begin
                    m_pc = nxt;
                    m_pv = 1'b0;
                end else if (redir) begin
                    m_pa = nxt;
                    m_pv = 1'b1;
                end
            end
            m_phase = (r_src == 2'b00) ? 1 : ((m_phase == 2) ? 2 : m_phase + 1);

            @(posedge clk);
            #1;
            check_regs("rnd", m_pc, m_phase == 2, m_pv);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
